// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target: FSM states, conf byte layout,
// filler byte and bit-order helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StShift
  } spi_state_e;

  // Configuration byte layout, common with the SPI master.
  localparam int unsigned CONF_CS_POL    = 7;
  localparam int unsigned CONF_CPOL      = 6;
  localparam int unsigned CONF_CPHA      = 5;
  localparam int unsigned CONF_FIRST_BIT = 4;

  // Returned on MISO when the master clocks a byte that was never loaded.
  localparam logic [7:0] SPI_FILL_BYTE = 8'hFF;

  // Bit that goes out next: MSB when lsb_first=0, LSB otherwise.
  function automatic logic head_bit(input logic [7:0] v, input logic lsb_first);
    return lsb_first ? v[0] : v[7];
  endfunction

  // Drop the head bit and move the next one into head position.
  function automatic logic [7:0] advance(input logic [7:0] v, input logic lsb_first);
    return lsb_first ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one SPI pin with registered rise/fall pulses.
// The reset value is an input so the chain comes out of reset at the pin's
// idle level and produces no spurious edge or chip-select event.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic rst_val,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the pin through the chain and register edge pulses off the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{rst_val}};
      prev  <= rst_val;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign level = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target: 8-bit frames, all pins oversampled in the clk domain.
// One-byte TX holding register and one-byte RX register with valid/ack.
// Optional: define SPI_SLAVE_OVERRUN_EN to enable the sticky rx_ovr flag;
// otherwise rx_ovr is tied to 0.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] conf,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_ovr,
  output logic       busy,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic       spi_cs_n
);

  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic cs_level, cs_rise, cs_fall;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk     (clk),
    .rst     (rst),
    .din     (spi_clk),
    .rst_val (conf[CONF_CPOL]),
    .level   (sck_level),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .din     (spi_mosi),
    .rst_val (1'b0),
    .level   (mosi_level),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .din     (spi_cs_n),
    .rst_val (~conf[CONF_CS_POL]),
    .level   (cs_level),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  logic unused_sigs;
  assign unused_sigs = ^{conf[3:0], sck_level, mosi_rise, mosi_fall, cs_rise, cs_fall};

  spi_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_tx;
  logic [7:0] shift_rx;
  logic [7:0] hold;
  logic       cpol_q, cpha_q, lsb_q;

  logic       cs_active;
  logic       lead_ev, trail_ev, sample_ev, drive_ev;
  logic [7:0] rx_next;
  logic [7:0] reload_byte;
  logic       arm_lsb;

  // Edge classification and datapath next values.
  always_comb begin
    cs_active   = (cs_level == conf[CONF_CS_POL]);  // cs_pol stays live
    lead_ev     = cpol_q ? sck_fall : sck_rise;
    trail_ev    = cpol_q ? sck_rise : sck_fall;
    sample_ev   = cpha_q ? trail_ev : lead_ev;
    drive_ev    = cpha_q ? lead_ev : trail_ev;
    rx_next     = lsb_q ? {mosi_level, shift_rx[7:1]} : {shift_rx[6:0], mosi_level};
    reload_byte = tx_empty ? SPI_FILL_BYTE : hold;
    arm_lsb     = conf[CONF_FIRST_BIT];
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic ovr_q;
  assign rx_ovr = ovr_q;
`else
  assign rx_ovr = 1'b0;
`endif

  assign busy = (state != StIdle);

  // FSM plus TX holding and RX registers; later assignments win on collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      bit_cnt  <= 3'd0;
      shift_tx <= 8'h00;
      shift_rx <= 8'h00;
      hold     <= 8'h00;
      tx_empty <= 1'b1;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      spi_miso <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      ovr_q    <= 1'b0;
`endif
    end else begin
      if (rx_ack) begin
        rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        ovr_q    <= 1'b0;
`endif
      end

      unique case (state)
        StIdle: begin
          spi_miso <= 1'b0;
          bit_cnt  <= 3'd0;
          if (cs_active) state <= StArm;
        end

        StArm: begin
          cpol_q   <= conf[CONF_CPOL];
          cpha_q   <= conf[CONF_CPHA];
          lsb_q    <= arm_lsb;
          tx_empty <= 1'b1;
          bit_cnt  <= 3'd0;
          shift_rx <= 8'h00;
          if (!conf[CONF_CPHA]) begin
            // CPHA=0: first bit must be on the pin before the first leading edge.
            spi_miso <= head_bit(reload_byte, arm_lsb);
            shift_tx <= advance(reload_byte, arm_lsb);
          end else begin
            shift_tx <= reload_byte;
          end
          state <= StShift;
        end

        StShift: begin
          if (!cs_active) begin
            state    <= StIdle;
            spi_miso <= 1'b0;
            bit_cnt  <= 3'd0;
          end else if (drive_ev) begin
            spi_miso <= head_bit(shift_tx, lsb_q);
            shift_tx <= advance(shift_tx, lsb_q);
          end else if (sample_ev) begin
            shift_rx <= rx_next;
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
              if (rx_valid && !rx_ack) ovr_q <= 1'b1;
`endif
              bit_cnt  <= 3'd0;
              // Reload without driving; the next drive edge shows the new head bit.
              shift_tx <= reload_byte;
              tx_empty <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        default: state <= StIdle;
      endcase

      if (tx_load) begin
        hold     <= tx_data;
        tx_empty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave, acting as the SPI master.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] conf;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_ovr;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  logic cpol, cpha, lsb;

  int checks = 0;
  int errors = 0;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .conf     (conf),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_empty (tx_empty),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .rx_ovr   (rx_ovr),
    .busy     (busy),
    .spi_clk  (sck),
    .spi_mosi (mosi),
    .spi_miso (miso),
    .spi_cs_n (cs_n)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic p, input logic h, input logic l);
    cpol = p;
    cpha = h;
    lsb  = l;
    conf = {1'b0, p, h, l, 4'b0000};
    sck  = p;
    wait_clk(HALF);
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
  endtask

  // Master side of one CS frame of nbits; MISO bits are reassembled per byte.
  task automatic xfer(input int nbits, input logic [7:0] b0, input logic [7:0] b1,
                      input bit ack_mid, output logic [7:0] g0, output logic [7:0] g1);
    logic [7:0] cur;
    logic       rec;
    int         pos;
    g0   = 8'h00;
    g1   = 8'h00;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      cur = (i < 8) ? b0 : b1;
      pos = lsb ? (i % 8) : 7 - (i % 8);
      if (!cpha) begin
        mosi = cur[pos];
        wait_clk(HALF);
        rec = miso;
        sck = ~cpol;
        wait_clk(HALF);
        sck = cpol;
      end else begin
        wait_clk(HALF);
        sck  = ~cpol;
        mosi = cur[pos];
        wait_clk(HALF);
        rec = miso;
        sck = cpol;
      end
      if (i < 8) g0[pos] = rec;
      else g1[pos] = rec;
      if (i == 7 && nbits > 8) begin
        wait_clk(6);
        if (ack_mid) begin
          check("mid_rx_valid", rx_valid, 1);
          check("mid_rx_data", rx_data, b0);
          pulse_ack();
        end
      end
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  logic [7:0] g0, g1, b0, b1, lv;
  bit         loaded;
  int         nb;
  logic       exp_ovr;

  initial begin
    rst = 1'b1; conf = 8'h00; tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0;
    sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; cpol = 0; cpha = 0; lsb = 0;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    wait_clk(3);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_ovr", rx_ovr, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    rst = 1'b0;
    wait_clk(4);

    // Mode 0 MSB first
    set_mode(0, 0, 0);
    load(8'hA5);
    check("m0_tx_empty_loaded", tx_empty, 0);
    xfer(8, 8'h3C, 8'h00, 0, g0, g1);
    check("m0_miso", g0, 8'hA5);
    check("m0_rx_data", rx_data, 8'h3C);
    check("m0_rx_valid", rx_valid, 1);
    check("m0_tx_empty", tx_empty, 1);
    check("m0_miso_idle", miso, 0);
    pulse_ack();
    check("m0_ack", rx_valid, 0);

    // Mode 3 LSB first
    set_mode(1, 1, 1);
    load(8'h01);
    xfer(8, 8'h80, 8'h00, 0, g0, g1);
    check("m3_miso", g0, 8'h01);
    check("m3_rx_data", rx_data, 8'h80);
    pulse_ack();

    // Two-byte frame, one byte loaded, ack between bytes
    set_mode(0, 0, 0);
    load(8'h5A);
    xfer(16, 8'h12, 8'h34, 1, g0, g1);
    check("two_miso0", g0, 8'h5A);
    check("two_miso1", g1, 8'hFF);
    check("two_rx_data", rx_data, 8'h34);
    check("two_rx_valid", rx_valid, 1);
    pulse_ack();

    // Two bytes without ack: overwrite and overrun; holding overwrite too
    set_mode(0, 1, 0);
    load(8'h66);
    load(8'h77);
    xfer(16, 8'h11, 8'h22, 0, g0, g1);
    check("ovr_miso0", g0, 8'h77);
    check("ovr_miso1", g1, 8'hFF);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_flag", rx_ovr, exp_ovr);
    pulse_ack();
    check("ovr_ack_valid", rx_valid, 0);
    check("ovr_ack_flag", rx_ovr, 0);

    // Abort after 5 bits, then a full frame
    set_mode(0, 0, 0);
    xfer(5, 8'hFF, 8'h00, 0, g0, g1);
    check("abort_busy", busy, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_miso", miso, 0);
    xfer(8, 8'hC3, 8'h00, 0, g0, g1);
    check("after_abort_rx_data", rx_data, 8'hC3);
    check("after_abort_rx_valid", rx_valid, 1);

    // Reset mid-byte (rx_valid still set from the previous frame)
    cs_n = 1'b0; mosi = 1'b1;
    wait_clk(HALF); sck = 1'b1;
    wait_clk(HALF); sck = 1'b0;
    wait_clk(HALF); sck = 1'b1;
    load(8'h99);
    wait_clk(2);
    rst = 1'b1;
    wait_clk(1);
    check("mrst_tx_empty", tx_empty, 1);
    check("mrst_rx_data", rx_data, 8'h00);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_rx_ovr", rx_ovr, 0);
    check("mrst_busy", busy, 0);
    check("mrst_miso", miso, 0);
    rst = 1'b0; cs_n = 1'b1; sck = 1'b0;
    wait_clk(10);
    xfer(8, 8'h7E, 8'h00, 0, g0, g1);
    check("mrst_frame_rx_data", rx_data, 8'h7E);
    check("mrst_frame_miso", g0, 8'hFF);
    pulse_ack();

    // Randomized frames against the byte-level model
    for (int r = 0; r < 12; r++) begin
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      loaded = 1'($urandom_range(0, 1));
      lv = 8'($urandom);
      if (loaded) load(lv);
      nb = $urandom_range(1, 2);
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      xfer(nb * 8, b0, b1, 1, g0, g1);
      check("rnd_miso0", g0, loaded ? lv : 8'hFF);
      if (nb == 2) check("rnd_miso1", g1, 8'hFF);
      check("rnd_rx_data", rx_data, (nb == 2) ? b1 : b0);
      check("rnd_rx_valid", rx_valid, 1);
      check("rnd_rx_ovr", rx_ovr, 0);
      check("rnd_tx_empty", tx_empty, 1);
      pulse_ack();
      check("rnd_ack", rx_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI target (slave) that receives and transmits 8-bit frames over an externally generated SPI clock, with all SPI pins oversampled in the single system clock domain. It is the peripheral-side counterpart to the team's SPI master and uses the same configuration byte layout. On the system side it exposes a one-byte TX holding register and a one-byte RX register with valid/ack handshakes.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on spi_clk, spi_mosi and spi_cs_n (minimum 2).

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  reset, synchronous, active-high.
- conf  in  8  {cs_pol, cpol, cpha, first_bit, 4'b reserved}; first_bit=1 selects LSB first.
- tx_data  in  8  byte to return on MISO.
- tx_load  in  1  one-cycle strobe; writes tx_data into the holding register.
- tx_empty  out  1  holding register empty; reset 1.
- rx_data  out  8  last complete received byte; reset 8'h00.
- rx_valid  out  1  rx_data holds an unread byte; reset 0.
- rx_ack  in  1  clears rx_valid (and rx_ovr).
- rx_ovr  out  1  sticky overrun flag; reset 0.
- busy  out  1  chip select active (state ≠ IDLE); reset 0.
- spi_clk  in  1  SPI clock from master.
- spi_mosi  in  1  master out, slave in.
- spi_miso  out  1  slave out; reset 0, and 0 whenever CS is inactive.
- spi_cs_n  in  1  chip select; active level equals cs_pol.

## Operation
- Synchronize the three SPI inputs through SYNC_STAGES flops, plus one extra flop on spi_clk for edge detection.
- Leading edge: synced spi_clk moves away from cpol. Trailing edge: it returns to cpol.
- CPHA=0: sample on leading edges and drive on trailing edges. CPHA=1: drive on leading edges and sample on trailing edges.
- FSM states: IDLE, ARM, SHIFT.
- IDLE: spi_miso=0, bit counter=0. CS active → ARM.
- ARM (one cycle):
  - latch cpol, cpha and first_bit; cs_pol stays live;
  - shift_tx ← holding register, or 8'hFF filler if tx_empty; set tx_empty=1;
  - if CPHA=0, drive the head bit onto spi_miso and advance;
  - → SHIFT.
- SHIFT:
  - drive edge: spi_miso ← head bit, then advance;
  - sample edge: insert synced MOSI into shift_rx, bit_cnt+1.
- Head bit is shift_tx[7] when first_bit=0 and shift_tx[0] when first_bit=1. Received bits are placed so that rx_data matches the master's tx_data in both bit orders.
- 8th sample edge:
  - rx_data ← assembled byte, rx_valid ← 1, bit_cnt ← 0 (wrap);
  - shift_tx reloads exactly as in ARM, but does not drive; the next drive edge presents the new byte's first bit.
- CS inactive in SHIFT (mid-byte or at a byte boundary) → IDLE. Partial bits are discarded and rx_valid is untouched.
- Simultaneous events:
  - tx_load on the reload cycle: reload uses the old holding content; the holding register takes the new byte and tx_empty stays 0.
  - tx_load while not empty: overwrite.
  - rx_ack on the cycle a byte completes: set wins, so rx_valid stays 1.
- rst in any state: every output goes to its reset value on the next clk edge; the transfer is aborted.

## Timing
- Pin change → internal event: SYNC_STAGES+1 clk.
- CS assert → first MISO bit (CPHA=0): SYNC_STAGES+2 clk (4 with default).
- Final sample pin edge → rx_valid=1: SYNC_STAGES+2 clk.
- Drive pin edge → spi_miso update: SYNC_STAGES+2 clk.
- Master constraints:
  - SCK half-period ≥ SYNC_STAGES+3 clk;
  - CS-assert-to-first-edge ≥ SYNC_STAGES+3 clk;
  - CS deassert between frames ≥ 2 clk.
- rx_ack and tx_load are single-cycle and take effect on the next clk.

## Configuration
- SPI_SLAVE_OVERRUN_EN defined:
  - when a byte completes while rx_valid=1 and rx_ack is not asserted that cycle, rx_ovr ← 1;
  - rx_ovr is sticky until rx_ack;
  - rx_data is overwritten with the newer byte.
- Undefined: rx_ovr is tied to 0. Overwrite behaviour is unchanged.

## Structure
- Package spi_pkg: FSM state encoding, conf bit indices (CONF_CS_POL=7, CONF_CPOL=6, CONF_CPHA=5, CONF_FIRST_BIT=4), SPI_FILL_BYTE=8'hFF.
- Sub-module spi_sync: SYNC_STAGES synchronizer with rise/fall pulse outputs. One instance each for spi_clk, spi_mosi and spi_cs_n.

## Test plan
- Mode 0, MSB first: load 0xA5, master sends 0x3C → MISO 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1; tx_empty=1.
- Mode 3, LSB first: load 0x01, master sends 0x80 → first MISO bit 1, rest 0; rx_data=0x80.
- Two-byte frame with only 0x5A loaded → MISO returns 0x5A then 0xFF; two rx_valid events with rx_ack between them.
- Two bytes 0x11 then 0x22 with no rx_ack → rx_data=0x22; rx_ovr=1 with SPI_SLAVE_OVERRUN_EN, 0 without; rx_ack clears both flags.
- CS deasserted after 5 bits → busy=0, rx_valid stays 0, spi_miso=0; the following full frame 0xC3 is received correctly.
- rst asserted mid-byte → next cycle all outputs at reset values; a subsequent frame 0x7E completes normally.
